// File: rtl/enc83_pkg.sv
// Shared types for the 8-line event encoder and its priority picker.
//   N_LINES    : number of request lines
//   CODE_W     : width of an encoded line index
//   line_vec_t : one bit per request line
//   code_t     : encoded line index
package enc83_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned CODE_W  = 3;

  typedef logic [N_LINES-1:0] line_vec_t;
  typedef logic [CODE_W-1:0]  code_t;

endpackage

// File: rtl/event_encoder_83_if.sv
// Code output handshake of event_encoder_83.
//   code_valid : producer holds an unconsumed code
//   code       : index of the served line
//   code_ready : consumer accepts code while code_valid is high
// master = encoder side, slave = consumer side.
interface event_encoder_83_if;
  import enc83_pkg::*;

  logic  code_valid;
  code_t code;
  logic  code_ready;

  modport master (
    output code_valid,
    output code,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code,
    output code_ready
  );

endinterface

// File: rtl/prio_pick_8.sv
// Combinational priority picker over eight request bits.
//   HIGH_FIRST : 1 = bit 7 wins, 0 = bit 0 wins
//   vec_i      : request vector
//   code_o     : index of the winning bit (0 when nothing is set)
//   onehot_o   : winning bit alone (all zero when nothing is set)
//   any_o      : at least one bit of vec_i is set
module prio_pick_8
  import enc83_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  line_vec_t vec_i,
  output code_t     code_o,
  output line_vec_t onehot_o,
  output logic      any_o
);

  // Scan from the lowest-priority end so the last hit seen is the winner.
  always_comb begin
    code_o   = '0;
    onehot_o = '0;
    any_o    = |vec_i;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(N_LINES); i++) begin
        if (vec_i[i]) begin
          code_o      = code_t'(i);
          onehot_o    = '0;
          onehot_o[i] = 1'b1;
        end
      end
    end else begin
      for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
        if (vec_i[i]) begin
          code_o      = code_t'(i);
          onehot_o    = '0;
          onehot_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/event_encoder_83.sv
// Sequential 8-to-3 priority encoder. Falling edges on the active-low request
// lines are latched into a pending vector and drained one code per transfer,
// in priority order, over a valid/ready handshake.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   EI_n     : active-low capture enable (draining continues while high)
//   I_n      : active-low request lines, a 1->0 transition is one request
//   out_if   : code_valid / code / code_ready handshake (master side)
//   GS_n     : low while any request is pending or presented
//   EO_n     : low when enabled and idle, feeds EI_n of the next stage
//   drop_cnt : saturating count of requests lost to an already-pending line
module event_encoder_83
  import enc83_pkg::*;
#(
  parameter bit          HIGH_FIRST = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EI_n,
  input  line_vec_t           I_n,
  event_encoder_83_if.master  out_if,
  output logic                GS_n,
  output logic                EO_n,
  output logic [CNT_W-1:0]    drop_cnt
);

  line_vec_t        prev_n_q;
  line_vec_t        pending_q, pending_d;
  logic             valid_q, valid_d;
  code_t            code_q, code_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  line_vec_t fall_g;
  line_vec_t clr;
  logic      load;
  logic      drop_hit;
  code_t     pick_code;
  line_vec_t pick_onehot;
  logic      pick_any;

  prio_pick_8 #(
    .HIGH_FIRST (HIGH_FIRST)
  ) u_pick (
    .vec_i    (pending_q),
    .code_o   (pick_code),
    .onehot_o (pick_onehot),
    .any_o    (pick_any)
  );

  always_comb begin
    fall_g    = EI_n ? '0 : (prev_n_q & ~I_n);
    load      = !valid_q || out_if.code_ready;
    clr       = load ? pick_onehot : '0;
    // A new edge on the bit being served re-arms it rather than being lost.
    pending_d = (pending_q & ~clr) | fall_g;
    drop_hit  = |(fall_g & pending_q & ~clr);

    drop_d = drop_q;
    if (drop_hit && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end

    valid_d = valid_q;
    code_d  = code_q;
    if (load) begin
      valid_d = pick_any;
      if (pick_any) begin
        code_d = pick_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_n_q  <= '1;
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      drop_q    <= '0;
    end else begin
      prev_n_q  <= I_n;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      drop_q    <= drop_d;
    end
  end

  assign out_if.code_valid = valid_q;
  assign out_if.code       = code_q;
  assign GS_n              = ~(|pending_q | valid_q);
  assign EO_n              = EI_n | ~GS_n;
  assign drop_cnt          = drop_q;

endmodule

// File: tb/tb_event_encoder_83.sv
// Randomized bench for event_encoder_83: two instances (7-first with a 3-bit
// drop counter, 0-first with an 8-bit counter) share stimulus, and each is
// compared every cycle against a line-by-line reference model.
module tb_event_encoder_83;
  import enc83_pkg::*;

  logic      clk;
  logic      rst;
  logic      ei_n;
  line_vec_t i_n;
  logic      rdy;

  logic       gs_n_a, eo_n_a, gs_n_b, eo_n_b;
  logic [2:0] drop_a;
  logic [7:0] drop_b;

  event_encoder_83_if u_if_a ();
  event_encoder_83_if u_if_b ();

  assign u_if_a.code_ready = rdy;
  assign u_if_b.code_ready = rdy;

  event_encoder_83 #(
    .HIGH_FIRST (1'b1),
    .CNT_W      (3)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .EI_n     (ei_n),
    .I_n      (i_n),
    .out_if   (u_if_a.master),
    .GS_n     (gs_n_a),
    .EO_n     (eo_n_a),
    .drop_cnt (drop_a)
  );

  event_encoder_83 #(
    .HIGH_FIRST (1'b0),
    .CNT_W      (8)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .EI_n     (ei_n),
    .I_n      (i_n),
    .out_if   (u_if_b.master),
    .GS_n     (gs_n_b),
    .EO_n     (eo_n_b),
    .drop_cnt (drop_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model state, per instance: which lines hold an unserved request,
  // what is presented, how many requests were lost.
  bit        m_req[2][8];
  bit        m_valid[2];
  int        m_code[2];
  int        m_drop[2];
  int        m_prev[2][8];
  bit        m_hi_first[2] = '{1'b1, 1'b0};
  int        m_drop_max[2] = '{7, 255};

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit busy(input int j);
    bit b = m_valid[j];
    for (int k = 0; k < 8; k++) b |= m_req[j][k];
    return b;
  endfunction

  task automatic check_all();
    check("a.valid", int'(u_if_a.code_valid), int'(m_valid[0]));
    check("a.code",  int'(u_if_a.code),       m_code[0]);
    check("a.gs_n",  int'(gs_n_a),            busy(0) ? 0 : 1);
    check("a.eo_n",  int'(eo_n_a),            (ei_n || busy(0)) ? 1 : 0);
    check("a.drop",  int'(drop_a),            m_drop[0]);
    check("b.valid", int'(u_if_b.code_valid), int'(m_valid[1]));
    check("b.code",  int'(u_if_b.code),       m_code[1]);
    check("b.gs_n",  int'(gs_n_b),            busy(1) ? 0 : 1);
    check("b.eo_n",  int'(eo_n_b),            (ei_n || busy(1)) ? 1 : 0);
    check("b.drop",  int'(drop_b),            m_drop[1]);
  endtask

  // What one rising edge does to the model with the currently driven inputs.
  task automatic model_edge(input int j);
    int  served = -1;
    bit  lost   = 1'b0;
    bit  edge_k;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        m_req[j][k]  = 1'b0;
        m_prev[j][k] = 1;
      end
      m_valid[j] = 1'b0;
      m_code[j]  = 0;
      m_drop[j]  = 0;
      return;
    end
    if (!m_valid[j] || rdy) begin
      for (int p = 0; p < 8; p++) begin
        int k = m_hi_first[j] ? 7 - p : p;
        if (served < 0 && m_req[j][k]) served = k;
      end
      m_valid[j] = (served >= 0);
      if (served >= 0) m_code[j] = served;
    end
    for (int k = 0; k < 8; k++) begin
      edge_k = (m_prev[j][k] == 1) && (i_n[k] == 1'b0) && !ei_n;
      if (edge_k && m_req[j][k] && k != served) lost = 1'b1;
      if (edge_k)          m_req[j][k] = 1'b1;
      else if (k == served) m_req[j][k] = 1'b0;
      m_prev[j][k] = int'(i_n[k]);
    end
    if (lost && m_drop[j] < m_drop_max[j]) m_drop[j]++;
  endtask

  task automatic step(input logic [7:0] in_v, input logic ei_v, input logic rdy_v,
                      input logic rst_v);
    @(negedge clk);
    cyc++;
    check_all();
    i_n  = in_v;
    ei_n = ei_v;
    rdy  = rdy_v;
    rst  = rst_v;
    model_edge(0);
    model_edge(1);
  endtask

  task automatic repeat_step(input int n, input logic [7:0] in_v, input logic ei_v,
                             input logic rdy_v);
    for (int i = 0; i < n; i++) step(in_v, ei_v, rdy_v, 1'b0);
  endtask

  initial begin
    logic [7:0] r1, r2;
    i_n  = 8'hFF;
    ei_n = 1'b0;
    rdy  = 1'b1;
    rst  = 1'b1;
    model_edge(0);
    model_edge(1);
    step(8'hFF, 1'b0, 1'b1, 1'b1);
    repeat_step(2, 8'hFF, 1'b0, 1'b1);

    // Single request on line 4.
    repeat_step(1, 8'hEF, 1'b0, 1'b1);
    repeat_step(4, 8'hFF, 1'b0, 1'b1);

    // Simultaneous requests on lines 0, 2, 5, 7.
    repeat_step(1, 8'h5A, 1'b0, 1'b1);
    repeat_step(6, 8'hFF, 1'b0, 1'b1);

    // Same with backpressure.
    repeat_step(1, 8'h5A, 1'b0, 1'b0);
    repeat_step(4, 8'hFF, 1'b0, 1'b0);
    repeat_step(6, 8'hFF, 1'b0, 1'b1);

    // Line 3 toggled repeatedly while stalled: drops and saturation.
    for (int i = 0; i < 12; i++) begin
      step(8'hF7, 1'b0, 1'b0, 1'b0);
      step(8'hFF, 1'b0, 1'b0, 1'b0);
    end
    repeat_step(4, 8'hFF, 1'b0, 1'b1);

    // Enable gating: capture one request, then disable and toggle everything.
    repeat_step(1, 8'hEF, 1'b0, 1'b0);
    repeat_step(1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1, 1'b0, 1'b0);
      step(8'hFF, 1'b1, 1'b0, 1'b0);
    end
    repeat_step(4, 8'hFF, 1'b1, 1'b1);
    repeat_step(2, 8'hFF, 1'b0, 1'b1);

    // Reset while everything is pending and a code is presented.
    repeat_step(3, 8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    repeat_step(3, 8'h00, 1'b0, 1'b0);
    repeat_step(10, 8'hFF, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      step(~(r1 & r2), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 149) == 0));
    end

    @(negedge clk);
    cyc++;
    check_all();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
